// File: rtl/serv_csr_seq_pkg.sv
// Shared types and counter constants for the bit-serial instruction sequencer.
package serv_csr_seq_pkg;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    TRAP = 2'd3
  } state_t;
endpackage

// File: rtl/serv_bit_cnt.sv
// 5-bit bit-serial position counter with the bit-position decodes the datapath needs.
// Decodes are combinational from the counter register and gated by the pass-enable.
module serv_bit_cnt
  import serv_csr_seq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_cnt0to3,
  output logic o_cnt3,
  output logic o_cnt7,
  output logic o_done
);

  logic [CNT_W-1:0] cnt_q;

  // Passes are exactly 32 cycles, so the natural wrap leaves cnt at 0 in IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_cnt0to3 = i_en & (cnt_q < CNT_W'(4));
  assign o_cnt3    = i_en & (cnt_q == CNT_W'(3));
  assign o_cnt7    = i_en & (cnt_q == CNT_W'(7));
  assign o_done    = i_en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/serv_csr_seq.sv
// Fetch/INIT/RUN/TRAP sequencer for a bit-serial core; each pass is 32 cycles.
// Interrupt entry (IDLE->TRAP on a pending timer irq) exists only with SERV_CSR_SEQ_IRQ_EN.
module serv_csr_seq
  import serv_csr_seq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ibus_ack,
  input  logic i_two_stage,
  input  logic i_e_op,
  input  logic i_misalign,
  input  logic i_new_irq,
  output logic o_ibus_cyc,
  output logic o_init,
  output logic o_cnt_en,
  output logic o_cnt0to3,
  output logic o_cnt3,
  output logic o_cnt7,
  output logic o_cnt_done,
  output logic o_trap,
  output logic o_trap_irq,
  output logic o_pc_en
);

  state_t state_q, state_d;
  logic   ibus_cyc_q, init_q, trap_q;
  logic   irq_pend;

  assign o_cnt_en = (state_q != IDLE);

  serv_bit_cnt u_bit_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (o_cnt_en),
    .o_cnt0to3 (o_cnt0to3),
    .o_cnt3    (o_cnt3),
    .o_cnt7    (o_cnt7),
    .o_done    (o_cnt_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_ibus_ack) state_d = irq_pend ? TRAP : (i_two_stage ? INIT : RUN);
      INIT: if (o_cnt_done) state_d = i_misalign ? TRAP : RUN;
      RUN:  if (o_cnt_done) state_d = i_e_op ? TRAP : IDLE;
      TRAP: if (o_cnt_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ibus_cyc_q <= 1'b1;
      init_q     <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ibus_cyc_q <= (state_d == IDLE);
      init_q     <= (state_d == INIT);
      trap_q     <= (state_d == TRAP);
    end
  end

  assign o_ibus_cyc = ibus_cyc_q;
  assign o_init     = init_q;
  assign o_trap     = trap_q;
  assign o_pc_en    = o_cnt_done & (((state_q == RUN) & ~i_e_op) | (state_q == TRAP));

`ifdef SERV_CSR_SEQ_IRQ_EN
  logic irq_pend_q, trap_irq_q, irq_take;

  assign irq_take = (state_q == IDLE) & i_ibus_ack & irq_pend_q;

  // Clearing on trap entry takes priority over a coincident new irq pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      irq_pend_q <= 1'b0;
      trap_irq_q <= 1'b0;
    end else begin
      if (irq_take) begin
        irq_pend_q <= 1'b0;
      end else if (i_new_irq) begin
        irq_pend_q <= 1'b1;
      end
      if (state_d != TRAP) begin
        trap_irq_q <= 1'b0;
      end else if (state_q != TRAP) begin
        trap_irq_q <= (state_q == IDLE);
      end
    end
  end

  assign irq_pend   = irq_pend_q;
  assign o_trap_irq = trap_irq_q;
`else
  logic unused_new_irq;

  assign unused_new_irq = i_new_irq;
  assign irq_pend       = 1'b0;
  assign o_trap_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_serv_csr_seq.sv
// Randomized bench for serv_csr_seq: each fetched instruction is expanded into its list of passes.
module tb_serv_csr_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ack, ts, eop, mis, new_irq;
  logic o_ibus_cyc, o_init, o_cnt_en, o_cnt0to3, o_cnt3, o_cnt7;
  logic o_cnt_done, o_trap, o_trap_irq, o_pc_en;

`ifdef SERV_CSR_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam int K_INIT = 0;
  localparam int K_RUN  = 1;
  localparam int K_TEXC = 2;
  localparam int K_TIRQ = 3;
  localparam logic [9:0] IDLE_V = 10'b10_0000_0000;

  serv_csr_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ibus_ack  (ack),
    .i_two_stage (ts),
    .i_e_op      (eop),
    .i_misalign  (mis),
    .i_new_irq   (new_irq),
    .o_ibus_cyc  (o_ibus_cyc),
    .o_init      (o_init),
    .o_cnt_en    (o_cnt_en),
    .o_cnt0to3   (o_cnt0to3),
    .o_cnt3      (o_cnt3),
    .o_cnt7      (o_cnt7),
    .o_cnt_done  (o_cnt_done),
    .o_trap      (o_trap),
    .o_trap_irq  (o_trap_irq),
    .o_pc_en     (o_pc_en)
  );

  // {ibus_cyc, init, cnt_en, cnt0to3, cnt3, cnt7, cnt_done, trap, trap_irq, pc_en}
  logic [9:0] obs;
  assign obs = {o_ibus_cyc, o_init, o_cnt_en, o_cnt0to3, o_cnt3, o_cnt7,
                o_cnt_done, o_trap, o_trap_irq, o_pc_en};

  int checks = 0;
  int errors = 0;
  bit pend   = 1'b0;

  task automatic check(input string tag, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic idle_cycle(input bit a, input bit t, input bit e, input bit m,
                            input bit irq, input string tag);
    @(negedge clk);
    ack = a; ts = t; eop = e; mis = m; new_irq = irq;
    #1;
    check(tag, obs, IDLE_V);
  endtask

  // irq_at: -1 none, -2 pulse on the ack cycle, >=0 pulse at that cycle of the instruction.
  task automatic run_instr(input bit t, input bit e, input bit m, input int gap,
                           input int irq_at, input int abort_at);
    int  kinds[$];
    bit  take;
    int  g;
    logic [9:0] exp;
    for (int i = 0; i < gap; i++)
      idle_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "idle");
    idle_cycle(1'b1, t, e, m, irq_at == -2, "ack");
    take = IRQ_EN && pend;
    if (take) pend = 1'b0;
    else if (IRQ_EN && irq_at == -2) pend = 1'b1;

    if (take) kinds.push_back(K_TIRQ);
    else begin
      if (t) kinds.push_back(K_INIT);
      if (t && m) kinds.push_back(K_TEXC);
      else begin
        kinds.push_back(K_RUN);
        if (e) kinds.push_back(K_TEXC);
      end
    end

    g = 0;
    foreach (kinds[p]) begin
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        ack     = 1'($urandom);
        ts      = 1'($urandom);
        eop     = (kinds[p] == K_RUN)  ? e : 1'($urandom);
        mis     = (kinds[p] == K_INIT) ? m : 1'($urandom);
        new_irq = (g == irq_at);
        rst_n   = !(g == abort_at);
        #1;
        exp = {1'b0, kinds[p] == K_INIT, 1'b1, k < 4, k == 3, k == 7, k == 31,
               kinds[p] >= K_TEXC, kinds[p] == K_TIRQ,
               (k == 31) && ((kinds[p] == K_RUN && !e) || kinds[p] >= K_TEXC)};
        check($sformatf("pass%0d_kind%0d_cnt%0d", p, kinds[p], k), obs, exp);
        if (IRQ_EN && g == irq_at) pend = 1'b1;
        if (g == abort_at) begin
          pend = 1'b0;
          @(negedge clk);
          rst_n = 1'b1; ack = 1'b0; new_irq = 1'b0;
          #1;
          check("after_reset_abort", obs, IDLE_V);
          return;
        end
        g++;
      end
    end
  endtask

  initial begin
    int r, ia;
    rst_n = 1'b0; ack = 1'b0; ts = 1'b0; eop = 1'b0; mis = 1'b0; new_irq = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state");

    run_instr(1'b0, 1'b0, 1'b0, 1, -1, -1);       // single RUN pass
    run_instr(1'b1, 1'b0, 1'b0, 0, -1, -1);       // INIT then RUN
    run_instr(1'b0, 1'b1, 1'b0, 0, -1, -1);       // ecall: RUN then exception TRAP
    run_instr(1'b0, 1'b0, 1'b0, 0, 10, -1);       // irq at RUN cnt=10
    run_instr(1'b0, 1'b0, 1'b0, 1, -1, -1);       // irq trap when enabled, else RUN
    run_instr(1'b0, 1'b0, 1'b0, 0, -1, -1);
    run_instr(1'b1, 1'b0, 1'b1, 0, -1, -1);       // misaligned: INIT then TRAP
    run_instr(1'b0, 1'b1, 1'b0, 0, -1, 32 + 17);  // reset at TRAP cnt=17
    run_instr(1'b0, 1'b0, 1'b0, 0, -1, -1);

    repeat (40) begin
      r = $urandom_range(9);
      ia = (r < 3) ? int'($urandom_range(95)) : ((r == 3) ? -2 : -1);
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(3)), ia, -1);
    end
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
